// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and the command record shared by the ALU issue stage.
package alu_pkg;
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOT  = 4'b0111;
   localparam logic [3:0] OP_SHL  = 4'b1000;
   localparam logic [3:0] OP_SHR  = 4'b1001;
   localparam logic [3:0] OP_LAST = 4'b1001;

   localparam int FLG_ZERO  = 0;
   localparam int FLG_CARRY = 1;
   localparam int FLG_OVF   = 2;
   localparam int FLG_DBZ   = 3;
   localparam int FLG_ILL   = 4;

   localparam int CMD_WIDTH = 8;
   localparam int CMD_TAG_W = 4;

   // Default-width command record; the top builds the same layout at its own WIDTH/TAG_W.
   typedef struct packed {
      logic [3:0]           sel;
      logic [CMD_WIDTH-1:0] a;
      logic [CMD_WIDTH-1:0] b;
      logic                 use_acc;
      logic [CMD_TAG_W-1:0] tag;
   } alu_cmd_t;
endpackage

// File: rtl/alu_issue_stage_fifo.sv
// alu_cmd_fifo: synchronous-reset command FIFO with occupancy output; full blocks pushes, empty blocks pops.
module alu_cmd_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   level_q, level_d;
   logic          do_push, do_pop;

   assign full  = level_q == (AW+1)'(DEPTH);
   assign empty = level_q == '0;
   assign level = level_q;
   assign dout  = mem_q[rd_q];

   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      mem_d   = mem_q;
      if (do_push) mem_d[wr_q] = din;
      wr_d    = do_push ? wr_q + 1'b1 : wr_q;
      rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
      level_d = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: queues ALU commands, drives alu_design from the FIFO head and captures results into a valid/ready slot.
module alu_issue_stage #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_sel,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   input  logic                     in_use_acc,
   input  logic [TAG_W-1:0]         in_tag,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   output logic [3:0]               alu_sel,
   input  logic [WIDTH-1:0]         alu_result,
   input  logic [WIDTH-1:0]         alu_quotient,
   input  logic [WIDTH-1:0]         alu_remainder,
   input  logic                     alu_carry,
   input  logic                     alu_overflow,
   input  logic                     alu_zero,
   input  logic                     alu_div_by_zero,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_result,
   output logic [WIDTH-1:0]         out_remainder,
   output logic [4:0]               out_flags,
   output logic [TAG_W-1:0]         out_tag,
   output logic [WIDTH-1:0]         acc_value,
   output logic [CNT_W-1:0]         dbz_count,
   output logic [$clog2(DEPTH):0]   fifo_level
);
   import alu_pkg::*;

   typedef struct packed {
      logic [3:0]       sel;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             use_acc;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   cmd_t             in_cmd, head;
   logic             full, empty, issue, legal, is_div, dbz;
   logic [WIDTH-1:0] res, rem;
   logic [4:0]       flags;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] result_q, result_d, rem_q, rem_d, acc_q, acc_d;
   logic [4:0]       flags_q, flags_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign in_cmd   = '{sel: in_sel, a: in_a, b: in_b, use_acc: in_use_acc, tag: in_tag};
   assign in_ready = !full;

   alu_cmd_fifo #(.DW($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid && !full),
      .pop   (issue),
      .din   (in_cmd),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   always_comb begin
      alu_sel = empty ? '0 : head.sel;
      alu_b   = empty ? '0 : head.b;
      alu_a   = empty ? '0 : (head.use_acc ? acc_q : head.a);
      issue   = !empty && (!valid_q || out_ready);
      legal   = head.sel <= OP_LAST;
      is_div  = head.sel == OP_DIV;
      dbz     = is_div && alu_div_by_zero;
      res     = (!legal || dbz) ? '0 : (is_div ? alu_quotient : alu_result);
      rem     = (is_div && !dbz) ? alu_remainder : '0;
      flags   = '0;
      flags[FLG_ILL]   = !legal;
      flags[FLG_DBZ]   = legal && dbz;
      flags[FLG_OVF]   = legal && alu_overflow;
      flags[FLG_CARRY] = legal && alu_carry;
      // Divide reports zero on the captured quotient, not on alu_result.
      flags[FLG_ZERO]  = legal && (is_div ? res == '0 : alu_zero);
      valid_d  = issue ? 1'b1 : (out_ready ? 1'b0 : valid_q);
      result_d = issue ? res : result_q;
      rem_d    = issue ? rem : rem_q;
      flags_d  = issue ? flags : flags_q;
      tag_d    = issue ? head.tag : tag_q;
      acc_d    = (issue && legal && !dbz) ? res : acc_q;
      cnt_d    = (issue && dbz && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         rem_q    <= '0;
         flags_q  <= '0;
         tag_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         flags_q  <= flags_d;
         tag_q    <= tag_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid     = valid_q;
   assign out_result    = result_q;
   assign out_remainder = rem_q;
   assign out_flags     = flags_q;
   assign out_tag       = tag_q;
   assign acc_value     = acc_q;
   assign dbz_count     = cnt_q;
endmodule
